// File: rtl/cw_disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
package cw_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam int DEF_REFRESH_DIV  = 50000;
  localparam int DEF_BLINK_FRAMES = 64;

  typedef enum logic {
    ST_OFF,
    ST_SCAN
  } state_t;

endpackage

// File: rtl/cw_bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; non-decimal codes show a dash.
module cw_bcd_to_seg
  import cw_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/cw_disp_scan.sv
// Multiplexed 7-segment scanner with per-frame BCD snapshot (no tearing).
// Optional blinking of masked digits is enabled by defining CW_DISP_BLINK_EN.
module cw_disp_scan
  import cw_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int DIV_W       = 16
`ifdef CW_DISP_BLINK_EN
  , parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
`endif
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [4*NUM_DIGITS-1:0] i_Bcd,
`ifdef CW_DISP_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   i_Blink_Mask,
`endif
  output logic [6:0]              o_Seg,
  output logic [NUM_DIGITS-1:0]   o_Dig,
  output logic                    o_Frame_Start
);

  localparam int               IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0]        presc;
  logic                    scan_tick;
  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    take_snap;
  logic [4*NUM_DIGITS-1:0] snap, bcd_src;
  logic [3:0]              sel_bcd;
  logic [6:0]              dec_seg, seg_nxt;
  logic [NUM_DIGITS-1:0]   dig_nxt;

  assign scan_tick = (presc == DIV_LAST);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    take_snap = 1'b0;
    case (state)
      ST_OFF: begin
        if (scan_tick) begin
          state_nxt = ST_SCAN;
          idx_nxt   = '0;
          take_snap = 1'b1;
        end
      end
      ST_SCAN: begin
        if (scan_tick) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            take_snap = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // The registered outputs must show the newly selected digit on the same
  // edge a snapshot is taken, so the digit is picked from the live bus then.
  assign bcd_src = take_snap ? i_Bcd : snap;

  always_comb begin
    sel_bcd = '0;
    dig_nxt = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IDX_W'(k)) begin
        sel_bcd    = bcd_src[4*k +: 4];
        dig_nxt[k] = 1'b1;
      end
    end
  end

  cw_bcd_to_seg u_dec (
    .bcd (sel_bcd),
    .seg (dec_seg)
  );

`ifdef CW_DISP_BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);

  logic [FC_W-1:0]       frame_cnt;
  logic                  phase, phase_nxt, frame_wrap;
  logic [NUM_DIGITS-1:0] mask_snap, mask_src;

  assign frame_wrap = (state == ST_SCAN) && scan_tick && (idx == LAST_IDX);
  assign phase_nxt  = (frame_wrap && frame_cnt == FC_W'(BLINK_FRAMES - 1)) ? ~phase : phase;
  assign mask_src   = take_snap ? i_Blink_Mask : mask_snap;
  assign seg_nxt    = (phase_nxt && |(mask_src & dig_nxt)) ? SEG_OFF : dec_seg;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
      mask_snap <= '0;
    end else begin
      if (frame_wrap) begin
        frame_cnt <= (frame_cnt == FC_W'(BLINK_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
      end
      phase <= phase_nxt;
      if (take_snap) begin
        mask_snap <= i_Blink_Mask;
      end
    end
  end
`else
  assign seg_nxt = dec_seg;
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      presc         <= '0;
      state         <= ST_OFF;
      idx           <= '0;
      snap          <= '0;
      o_Seg         <= SEG_OFF;
      o_Dig         <= '0;
      o_Frame_Start <= 1'b0;
    end else begin
      presc         <= scan_tick ? '0 : presc + 1'b1;
      state         <= state_nxt;
      idx           <= idx_nxt;
      o_Frame_Start <= take_snap;
      if (take_snap) begin
        snap <= i_Bcd;
      end
      if (scan_tick) begin
        o_Dig <= dig_nxt;
        o_Seg <= seg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cw_disp_scan.sv
// Scoreboard bench for cw_disp_scan (REFRESH_DIV=4, NUM_DIGITS=6, default build).
module tb_cw_disp_scan;

  localparam int ND = 6;
  localparam int RD = 4;
  localparam int DW = 3;

  typedef struct packed {
    logic [ND-1:0] dig;
    logic [6:0]    seg;
    logic          fs;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [4*ND-1:0] bcd = '0;
  logic [6:0]      seg;
  logic [ND-1:0]   dig;
  logic            fs;

  exp_t            exp_q[$];
  int              checks = 0;
  int              errors = 0;
  int              edge_n = 0;
  logic            mon_en = 1'b0;
  logic [4*ND-1:0] frame_model = '0;
  logic [6:0]      seg_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  always #5 clk = ~clk;

  cw_disp_scan #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .DIV_W       (DW)
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Bcd         (bcd),
    .o_Seg         (seg),
    .o_Dig         (dig),
    .o_Frame_Start (fs)
  );

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Every RD-th edge after release starts a new slot; slot 0 of a frame
  // latches the bus as it stands on that edge.
  task automatic apply_stimulus(input logic [4*ND-1:0] v);
    exp_t e;
    int   k;
    bcd = v;
    edge_n++;
    if (edge_n % RD == 0) begin
      k = (edge_n / RD - 1) % ND;
      if (k == 0) frame_model = v;
      e.dig = ND'(1) << k;
      e.seg = seg_tab[frame_model[4*k +: 4]];
      e.fs  = (k == 0);
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    check_output("rst_dig", 16'(dig), 16'(0));
    check_output("rst_seg", 16'(seg), 16'(0));
    check_output("rst_fs", 16'(fs), 16'(0));
    exp_q.delete();
    @(negedge clk);
    rst    = 1'b0;
    edge_n = 0;
  endtask

  function automatic logic [4*ND-1:0] rand_bcd();
    logic [31:0] r;
    r = $urandom;
    return r[4*ND-1:0];
  endfunction

  initial begin
    logic [ND-1:0] last_dig;
    logic [6:0]    last_seg;
    exp_t          e;
    last_dig = '0;
    last_seg = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (rst) begin
          last_dig = '0;
          last_seg = '0;
        end else if (dig != last_dig) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_slot actual dig=%b seg=%h required no change at %0t",
                     dig, seg, $time);
          end else begin
            e = exp_q.pop_front();
            check_output("slot_dig", 16'(dig), 16'(e.dig));
            check_output("slot_seg", 16'(seg), 16'(e.seg));
            check_output("slot_fs", 16'(fs), 16'(e.fs));
          end
          last_dig = dig;
          last_seg = seg;
        end else begin
          check_output("hold_seg", 16'(seg), 16'(last_seg));
          check_output("hold_fs", 16'(fs), 16'(0));
        end
      end
    end
  end

  initial begin
    logic [4*ND-1:0] cur;
    bit              found;
    $display("[TB] start");
    @(negedge clk);
    reset_dut();
    mon_en = 1'b1;

    for (int i = 0; i < 61; i++) apply_stimulus(24'h123456);
    for (int i = 0; i < 48; i++) apply_stimulus(24'h123500);
    for (int i = 0; i < 24; i++) apply_stimulus(24'h12345B);

    cur = 24'h000000;
    for (int i = 0; i < 240; i++) begin
      if ($urandom_range(0, 3) == 0) cur = rand_bcd();
      apply_stimulus(cur);
    end

    found = 1'b0;
    for (int i = 0; i < 48 && !found; i++) begin
      if (dig == 6'b001000) found = 1'b1;
      else apply_stimulus(cur);
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_digit3 actual dig=%b required 001000 within 48 cycles", dig);
    end
    reset_dut();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) cur = rand_bcd();
      apply_stimulus(cur);
    end

    check_output("queue_drained", 16'(exp_q.size()), 16'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
